// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, move and result signals between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    modport master (output start, op, a, b, mthi, mtlo, input hi, lo, busy, done);
    modport slave (input start, op, a, b, mthi, mtlo, output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Multiply and divide share one 64-bit accumulator and operate on unsigned magnitudes.
module muldiv_unit (
    input logic           clk_i,
    input logic           rst_i,
    muldiv_unit_if.slave  bus_io
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] m_q, a_q, hi_q, lo_q;
    logic [63:0] acc_q, acc_d, prod;
    logic        sa_q, neg_q, bz_q, busy_q, done_q;
    logic        sa, sb;
    logic [31:0] abs_a, abs_b, res_hi, res_lo;
    logic [64:0] sh;
    logic [32:0] trial, msum;
    always_comb begin
        sa     = bus_io.op[0] & bus_io.a[31];
        sb     = bus_io.op[0] & bus_io.b[31];
        abs_a  = sa ? -bus_io.a : bus_io.a;
        abs_b  = sb ? -bus_io.b : bus_io.b;
        sh     = {acc_q, 1'b0};
        trial  = sh[64:32] - {1'b0, m_q};
        msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        acc_d  = op_q[1] ? (trial[32] ? sh[63:0] : {trial[31:0], sh[31:1], 1'b1})
                         : {msum, acc_q[31:1]};
        prod   = neg_q ? -acc_d : acc_d;
        // A zero divisor returns the raw dividend in HI regardless of sign handling
        res_hi = op_q[1] ? (bz_q ? a_q : (sa_q ? -acc_d[63:32] : acc_d[63:32])) : prod[63:32];
        res_lo = op_q[1] ? (bz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_d[31:0] : acc_d[31:0])) : prod[31:0];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            m_q     <= 32'd0;
            a_q     <= 32'd0;
            acc_q   <= 64'd0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == CALC) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                hi_q    <= res_hi;
                lo_q    <= res_lo;
            end
        end else if (bus_io.start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= 5'd0;
            op_q    <= bus_io.op;
            a_q     <= bus_io.a;
            sa_q    <= sa;
            neg_q   <= sa ^ sb;
            bz_q    <= bus_io.b == 32'd0;
            m_q     <= bus_io.op[1] ? abs_b : abs_a;
            acc_q   <= {32'd0, bus_io.op[1] ? abs_a : abs_b};
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            if (bus_io.mthi) hi_q <= bus_io.a;
            if (bus_io.mtlo) lo_q <= bus_io.a;
        end
    end
    assign bus_io.hi   = hi_q;
    assign bus_io.lo   = lo_q;
    assign bus_io.busy = busy_q;
    assign bus_io.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed stimulus checked every cycle against a countdown/arithmetic model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    muldiv_unit_if bus ();
    muldiv_unit dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0:    return {32'd0, a} * {32'd0, b};
            2'd1:    return 64'(sa * sb);
            2'd2:    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) {m_hi, m_lo} = m_pend;
        end else begin
            m_done = 1'b0;
            if (bus.start) begin
                m_left = 32;
                m_pend = ref_op(bus.op, bus.a, bus.b);
            end else begin
                if (bus.mthi) m_hi = bus.a;
                if (bus.mtlo) m_lo = bus.a;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, bus.done}, {31'd0, m_done});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
    endtask

    task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(op, a, b);
        wait_done(n);
        chk({nm, " latency"}, n, 32);
        chk({nm, " hi"}, bus.hi, eh);
        chk({nm, " lo"}, bus.lo, el);
    endtask

    initial begin
        int n;
        logic [63:0] r;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        r = ref_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pin multu", r[31:0] ^ r[63:32], 32'hFFFF_FFFF);
        r = ref_op(2'd1, 32'hFFFF_FFFD, 32'd7);
        chk("pin mult lo", r[31:0], 32'hFFFF_FFEB);
        r = ref_op(2'd3, 32'hFFFF_FFF9, 32'd2);
        chk("pin div hi", r[63:32], 32'hFFFF_FFFF);
        r = ref_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("pin div ovf lo", r[31:0], 32'h8000_0000);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        run("multu max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        run("mult -3*7", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div -7/2 b2b", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        run("divu 5/0", 2'd2, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
        run("div ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        @(negedge clk);
        bus.mthi = 1'b1;
        bus.a    = 32'h1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi idle hi", bus.hi, 32'h0000_1234);
        chk("mthi idle lo", bus.lo, 32'h8000_0000);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.op    = 2'd3;
        bus.a     = 32'h1234;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        wait_done(n);
        chk("calc ignore latency", n, 26);
        chk("calc ignore hi", bus.hi, 32'hFFFF_FFFE);
        chk("calc ignore lo", bus.lo, 32'h0000_0001);
        @(negedge clk);
        issue(2'd2, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, bus.busy}, 32'd0);
        chk("async rst done", {31'd0, bus.done}, 32'd0);
        chk("async rst hi", bus.hi, 32'd0);
        chk("async rst lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("divu 7/2 after rst", 2'd2, 32'd7, 32'd2, 32'd1, 32'd3);
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.mthi = 1'($urandom_range(0, 1));
                bus.mtlo = 1'($urandom_range(0, 1));
                bus.a    = $urandom;
                @(negedge clk);
            end
            bus.mthi = 1'($urandom_range(0, 1));
            bus.mtlo = 1'($urandom_range(0, 1));
            issue(2'($urandom_range(0, 3)), pick(), pick());
            n = 1;
            while (!bus.done && n < 40) begin
                bus.start = ($urandom_range(0, 7) == 0);
                bus.mthi  = 1'($urandom_range(0, 1));
                bus.mtlo  = 1'($urandom_range(0, 1));
                bus.a     = $urandom;
                bus.b     = $urandom;
                @(negedge clk);
                n++;
            end
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            bus.mtlo  = 1'b0;
            chk("rand latency", n, 33);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: none; operand and result widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  one-cycle request from EX stage to begin an operation.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  rs operand (multiplicand / dividend); also the mthi/mtlo write data.
REQ-007 b  input  32  rt operand (multiplier / divisor).
REQ-008 mthi  input  1  write a into HI.
REQ-009 mtlo  input  1  write a into LO.
REQ-010 hi  output  32  HI register, registered.
REQ-011 lo  output  32  LO register, registered.
REQ-012 busy  output  1  operation in progress; drives the hazard unit stall.
REQ-013 done  output  1  one-cycle pulse when hi/lo hold a new result.

Function
REQ-014 FSM states: IDLE, CALC, DONE.
REQ-015 IDLE or DONE with start=1 -> CALC at the next edge; operands and op are latched at that edge; the iteration counter is cleared to 0.
REQ-016 CALC: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle, on unsigned magnitudes; the counter increments 0..31.
REQ-017 CALC with counter=31 -> DONE; hi/lo are written at that same edge.
REQ-018 Latency: start sampled at edge N; hi/lo valid and done=1 in the cycle after edge N+32.
REQ-019 DONE -> IDLE at the next edge unless start=1.
REQ-020 busy=1 exactly while in CALC (32 cycles); busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-021 Signed ops: latch |a| and |b| with operand signs.
REQ-022 MULT: negate the 64-bit product iff the signs differ.
REQ-023 DIV: the quotient is negated iff the signs differ; the remainder takes the sign of a.
REQ-024 Multiply result: hi = product[63:32], lo = product[31:0].
REQ-025 Divide result: lo = quotient, hi = remainder.
REQ-026 Divide by zero (DIVU or DIV): hi = a, lo = 0xFFFFFFFF; latency unchanged.
REQ-027 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; 32-bit wrap with no exception.
REQ-028 start while in CALC is ignored; the operation in flight is unaffected.
REQ-029 mthi/mtlo in IDLE or DONE write a into hi/lo at the next edge; both may be asserted in the same cycle.
REQ-030 mthi/mtlo while in CALC are ignored.
REQ-031 start together with mthi/mtlo in the same cycle: start wins and the moves are ignored.
REQ-032 hi/lo are unchanged from reset until a completed operation or a move.

Reset
REQ-033 Reset asserted -> immediately (no clock edge needed): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-034 Reset asserted during CALC abandons the operation; no partial result ever reaches hi/lo.
REQ-035 The first start after reset deassertion behaves exactly per REQ-015 to REQ-018.

Verification
REQ-036 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 32 cycles; then done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU a=5, b=0 -> hi=0x00000005, lo=0xFFFFFFFF after 33 edges; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 Reset pulsed at CALC cycle 10 -> busy=0, hi=lo=0 without a clock edge; a following DIVU 7/2 gives lo=3, hi=1 with full latency.
REQ-040 start and mthi (a=0x1234) asserted during CALC -> both ignored; the original result lands on schedule. mthi a=0x1234 in IDLE -> hi=0x00001234 next cycle, lo unchanged.
REQ-041 Back-to-back: start asserted in the DONE cycle -> DONE then CALC with no IDLE cycle; the second result is valid 33 edges after the second start.
